// File: rtl/round_manager_pkg.sv
// round_manager_pkg: state/finish encodings, default timing constants and saturating score increment
package round_manager_pkg;
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_ROUND_OVER = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_t;
  localparam logic [1:0] FIN_NONE = 2'b00;
  localparam logic [1:0] FIN_P1 = 2'b01;
  localparam logic [1:0] FIN_P2 = 2'b11;
  localparam int DEF_CLKS_PER_SEC = 100_000_000;
  localparam int DEF_COUNTDOWN_SEC = 3;
  localparam int DEF_ROUND_SEC = 60;
  localparam int DEF_RESULT_SEC = 2;
  localparam int DEF_ROUNDS_TO_WIN = 2;
  function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
    return (v >= lim) ? v : v + 2'd1;
  endfunction
endpackage

// File: rtl/round_manager_second_ticker.sv
// second_ticker: counts CLKS_PER_SEC cycles (clk, reset, i_clr restarts at 0) and pulses o_tick for one cycle per second
module second_ticker #(
  parameter int CLKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = $clog2(CLKS_PER_SEC + 1);
  logic [W-1:0] r_cnt;
  assign o_tick = r_cnt == W'(CLKS_PER_SEC - 1);
  always_ff @(posedge clk)
    r_cnt <= (reset || i_clr || o_tick) ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/round_manager.sv
// round_manager: fighting-game match sequencer (start_btn/finish/health in; game reset, input gate, scores, timers, winner, state out)
module round_manager
  import round_manager_pkg::*;
#(
  parameter int CLKS_PER_SEC  = DEF_CLKS_PER_SEC,
  parameter int COUNTDOWN_SEC = DEF_COUNTDOWN_SEC,
  parameter int ROUND_SEC     = DEF_ROUND_SEC,
  parameter int RESULT_SEC    = DEF_RESULT_SEC,
  parameter int ROUNDS_TO_WIN = DEF_ROUNDS_TO_WIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic [1:0] finish,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  output logic       game_rst_n,
  output logic       inputs_enable,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [3:0] countdown,
  output logic [6:0] round_time,
  output logic [1:0] match_winner,
  output logic [2:0] state
);
  localparam logic [3:0] CD_LOAD = 4'(COUNTDOWN_SEC);
  localparam logic [6:0] RT_LOAD = 7'(ROUND_SEC);
  localparam logic [7:0] HOLD_LOAD = 8'(RESULT_SEC);
  localparam logic [1:0] WIN = 2'(ROUNDS_TO_WIN);
  state_t r_state, w_state;
  logic [3:0] r_countdown, w_countdown;
  logic [6:0] r_round_time, w_round_time;
  logic [7:0] r_hold, w_hold;
  logic [1:0] r_p1, w_p1, r_p2, w_p2, r_winner, w_winner;
  logic r_start_q, r_armed, r_game_rst_n, r_inputs_enable;
  logic w_tick, w_start_rise;
  // r_armed blocks a start level held through reset until it has been seen low
  assign w_start_rise = start_btn & ~r_start_q & r_armed;
  second_ticker #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_ticker (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_state != r_state),
    .o_tick(w_tick)
  );
  always_comb begin
    w_state = r_state;
    w_countdown = r_countdown;
    w_round_time = r_round_time;
    w_hold = r_hold;
    w_p1 = r_p1;
    w_p2 = r_p2;
    w_winner = r_winner;
    case (r_state)
      ST_IDLE: if (w_start_rise) begin
        w_state = ST_COUNTDOWN;
        w_countdown = CD_LOAD;
      end
      ST_COUNTDOWN: if (w_tick) begin
        w_state = (r_countdown == 4'd1) ? ST_FIGHT : ST_COUNTDOWN;
        w_countdown = (r_countdown == 4'd1) ? 4'd0 : r_countdown - 4'd1;
        w_round_time = (r_countdown == 4'd1) ? RT_LOAD : r_round_time;
      end
      ST_FIGHT: begin
        if (finish[0]) begin
          w_state = ST_ROUND_OVER;
          w_round_time = 7'd0;
          w_hold = HOLD_LOAD;
          w_p1 = finish[1] ? r_p1 : sat_inc(r_p1, WIN);
          w_p2 = finish[1] ? sat_inc(r_p2, WIN) : r_p2;
        end else if (r_round_time == 7'd0) begin
          w_state = ST_ROUND_OVER;
          w_hold = HOLD_LOAD;
          w_p1 = (p1_health > p2_health) ? sat_inc(r_p1, WIN) : r_p1;
          w_p2 = (p2_health > p1_health) ? sat_inc(r_p2, WIN) : r_p2;
        end else if (w_tick) begin
          w_round_time = r_round_time - 7'd1;
        end
      end
      ST_ROUND_OVER: if (w_tick) begin
        if (r_hold == 8'd1) begin
          w_state = (r_p1 == WIN || r_p2 == WIN) ? ST_MATCH_OVER : ST_COUNTDOWN;
          w_countdown = (r_p1 == WIN || r_p2 == WIN) ? 4'd0 : CD_LOAD;
          w_winner = (r_p1 == WIN) ? FIN_P1 : (r_p2 == WIN) ? FIN_P2 : FIN_NONE;
        end else begin
          w_hold = r_hold - 8'd1;
        end
      end
      ST_MATCH_OVER: if (w_start_rise) begin
        w_state = ST_COUNTDOWN;
        w_countdown = CD_LOAD;
        w_p1 = 2'd0;
        w_p2 = 2'd0;
        w_winner = FIN_NONE;
      end
      default: w_state = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_countdown <= 4'd0;
      r_round_time <= 7'd0;
      r_hold <= 8'd0;
      r_p1 <= 2'd0;
      r_p2 <= 2'd0;
      r_winner <= FIN_NONE;
      r_start_q <= 1'b0;
      r_armed <= ~start_btn;
      r_game_rst_n <= 1'b0;
      r_inputs_enable <= 1'b0;
    end else begin
      r_state <= w_state;
      r_countdown <= w_countdown;
      r_round_time <= w_round_time;
      r_hold <= w_hold;
      r_p1 <= w_p1;
      r_p2 <= w_p2;
      r_winner <= w_winner;
      r_start_q <= start_btn;
      r_armed <= r_armed | ~start_btn;
      r_game_rst_n <= r_state != ST_IDLE && r_state != ST_COUNTDOWN;
      r_inputs_enable <= r_state == ST_FIGHT;
    end
  end
  assign game_rst_n = r_game_rst_n;
  assign inputs_enable = r_inputs_enable;
  assign p1_rounds = r_p1;
  assign p2_rounds = r_p2;
  assign countdown = r_countdown;
  assign round_time = r_round_time;
  assign match_winner = r_winner;
  assign state = r_state;
endmodule
